// File: rtl/parity_pkg.sv
// Shared encodings for the serial parity checker.
// Covers the FSM state encoding and the parity-sense constants.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/xor_struct.sv
// Two-input XOR primitive used as the running-parity update in the parity path.
module xor_struct (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  xor u_xor (y_o, a_i, b_i);

endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames of DATA_BITS data bits plus one parity bit,
// and reports the word, a parity-error flag and a one-cycle frame strobe.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ODD_PARITY = PAR_EVEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 sop,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_valid
);

  localparam int            CW    = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST  = CW'(DATA_BITS);
  localparam logic          ODD_L = (ODD_PARITY != 0);

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   acc_q, acc_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   perr_q, perr_d;
  logic                   fv_q, fv_d;
  logic                   acc_x;

  xor_struct u_acc (
    .a_i (acc_q),
    .b_i (bit_in),
    .y_o (acc_x)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    shift_d = shift_q;
    data_d  = data_q;
    perr_d  = perr_q;
    fv_d    = 1'b0;
    if (bit_valid) begin
      // sop restarts from any state, overriding data/parity interpretation
      if (sop) begin
        state_d    = (DATA_BITS == 1) ? PARITY : DATA;
        cnt_d      = CW'(1);
        acc_d      = bit_in;
        shift_d    = '0;
        shift_d[0] = bit_in;
      end else begin
        case (state_q)
          DATA: begin
            for (int i = 0; i < DATA_BITS; i++) begin
              if (cnt_q == CW'(i)) shift_d[i] = bit_in;
            end
            acc_d = acc_x;
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == LAST) state_d = PARITY;
          end
          PARITY: begin
            data_d  = shift_q;
            perr_d  = (acc_x != ODD_L);
            fv_d    = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      shift_q <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      fv_q    <= fv_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign data_out    = data_q;
  assign parity_err  = perr_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even- and odd-parity instances share one stimulus stream.
module tb_serial_parity_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       sop = 1'b0;
  logic       busy_e, perr_e, fv_e;
  logic       busy_o, perr_o, fv_o;
  logic [7:0] data_e, data_o;

  int errors = 0;
  int checks = 0;
  int strobes = 0;
  int frames_sent = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] data;
    logic       par;
    bit         gaps;
    logic       exp_err;
  } vec_t;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sop(sop),
    .busy(busy_e), .data_out(data_e), .parity_err(perr_e), .frame_valid(fv_e)
  );

  serial_parity_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .sop(sop),
    .busy(busy_o), .data_out(data_o), .parity_err(perr_o), .frame_valid(fv_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic s);
    bit_valid = v;
    bit_in    = b;
    sop       = s;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    sop       = 1'b0;
  endtask

  task automatic stall(input int n);
    for (int k = 0; k < n; k++) begin
      bit_valid = 1'b0;
      bit_in    = 1'($urandom);
      sop       = 1'($urandom);
      @(posedge clk);
      #1;
    end
    sop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input bit gaps,
                            input logic exp_err, input bit chk_busy);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) stall(int'($urandom_range(0, 3)));
      step(1'b1, data[i], i == 0);
      if (chk_busy) check($sformatf("busy_bit%0d", i), {31'd0, busy_e}, 32'd1);
    end
    if (gaps) stall(int'($urandom_range(0, 3)));
    sb.push_back('{d: data, e: exp_err});
    frames_sent++;
    step(1'b1, par, 1'b0);
    if (chk_busy) check("busy_after_parity", {31'd0, busy_e}, 32'd0);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected frame.
  always @(negedge clk) begin
    if (fv_e || fv_o) begin
      exp_t x;
      strobes++;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_strobe: got data %0h expected no strobe", data_e);
      end else begin
        x = sb.pop_front();
        check("strobe_pair", {30'd0, fv_e, fv_o}, 32'd3);
        check("data_even", {24'd0, data_e}, {24'd0, x.d});
        check("perr_even", {31'd0, perr_e}, {31'd0, x.e});
        check("data_odd", {24'd0, data_o}, {24'd0, x.d});
        check("perr_odd", {31'd0, perr_o}, {31'd0, ~x.e});
        check("busy_at_strobe", {31'd0, busy_e}, 32'd0);
      end
    end
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{data: 8'hA5, par: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[1] = '{data: 8'hA5, par: 1'b1, gaps: 1'b0, exp_err: 1'b1};
    vecs[2] = '{data: 8'h00, par: 1'b1, gaps: 1'b0, exp_err: 1'b1};
    vecs[3] = '{data: 8'h00, par: 1'b0, gaps: 1'b0, exp_err: 1'b0};
    vecs[4] = '{data: 8'h3C, par: 1'b0, gaps: 1'b1, exp_err: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_data", {24'd0, data_e}, 32'd0);
    check("rst_perr", {31'd0, perr_e}, 32'd0);
    check("rst_fv", {31'd0, fv_e}, 32'd0);
    check("rst_busy", {31'd0, busy_e}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Valid bits without sop must not start a frame
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("idle_no_sop_busy", {31'd0, busy_e}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].data, vecs[v].par, vecs[v].gaps, vecs[v].exp_err, vecs[v].gaps);
      stall(2);
    end

    // Abort in DATA after 4 bits, then back-to-back frame with sop during the strobe cycle
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    stall(2);

    // Abort while waiting for the parity bit
    step(1'b1, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) step(1'b1, 1'(i), 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
    stall(2);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_data_e", {24'd0, data_e}, 32'd0);
    check("mid_rst_data_o", {24'd0, data_o}, 32'd0);
    check("mid_rst_perr_o", {31'd0, perr_o}, 32'd0);
    check("mid_rst_busy", {31'd0, busy_e}, 32'd0);
    check("mid_rst_fv", {31'd0, fv_e}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Remaining bits of the discarded frame must not produce a strobe
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("post_rst_idle", {31'd0, busy_e}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    stall(3);

    check("scoreboard_empty", sb.size(), 32'd0);
    check("strobe_count", strobes, frames_sent);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

endmodule
